mc_sequencer: RTL and testbench
===============================

# mc_sequencer

Multicycle control sequencer that turns the existing single-cycle RV32I datapath into a multicycle core sharing handshaked instruction and data memories. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It gates the datapath's state-changing strobes (PC update, instruction-register load, register-file write, data-memory write) and stalls on memory wait states. It also keeps cycle and retired-instruction counters and halts on SYSTEM opcodes, illegal opcodes or memory timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum consecutive wait cycles in FETCH or MEM before an error halt; must be ≥ 1.
- CNT_W, 32: width of `cycle_cnt` and `instret`.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- OpCode  in  7  `inst[6:0]` from the instruction register
- imem_ready  in  1  instruction memory has valid data this cycle
- dmem_ready  in  1  data memory has completed the access this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- IrWr  out  1  load instruction register this edge
- PcWr  out  1  commit next PC (`BuPp4Mux`) this edge
- RUWrEn  out  1  AND-gate on the control unit's `RUWr`
- DMWrEn  out  1  AND-gate on the control unit's `DMWr`
- halted  out  1  sequencer in HALT; sticky until reset
- error  out  1  halt cause: illegal opcode or timeout; sticky
- state  out  3  current state encoding, for debug
- cycle_cnt  out  CNT_W  cycles since reset, excluding HALT; wraps
- instret  out  CNT_W  retired instructions, counted as PcWr pulses; wraps

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Opcode classes:
  - ALU: 0110011, 0010011
  - LOAD: 0000011
  - STORE: 0100011
  - BRANCH: 1100011
  - JUMP: 1101111, 1100111
  - UPPER: 0110111, 0010111
  - SYSTEM: 1110011
  - Anything else is ILLEGAL.
- FETCH: `imem_req`=1. If `imem_ready`=1, then `IrWr`=1 and go to DECODE; otherwise stay.
- DECODE: one cycle; classify OpCode.
  - SYSTEM → HALT with `error`=0.
  - ILLEGAL → HALT with `error`=1.
  - All other classes → EXEC.
- EXEC: one cycle.
  - BRANCH: `PcWr`=1, go to FETCH.
  - LOAD or STORE: go to MEM.
  - All other classes: go to WB.
- MEM: `dmem_req`=1; for STORE, `DMWrEn`=1 on every MEM cycle.
  - On `dmem_ready`=1, LOAD goes to WB.
  - On `dmem_ready`=1, STORE pulses `PcWr` and goes to FETCH.
- WB: `RUWrEn`=1 and `PcWr`=1, then go to FETCH.
- HALT: all strobes and requests 0; stays in HALT until reset.
- Wait counter:
  - Increments on each FETCH or MEM cycle without ready; clears on ready or on any state change.
  - A request cycle without ready, entered with the count at TIMEOUT−1, goes to HALT with `error`=1 at the next edge.
- Exactly one `PcWr` per retired instruction; `instret` increments on that edge.
- The class is captured in a register in DECODE. EXEC, MEM and WB use the registered class, not the live OpCode.

## Timing
- Outputs are combinational from state, registered class and ready inputs (Mealy on ready). All outputs are forced to 0 while `rst_n`=0.
- First rising edge with `rst_n`=0 sets:
  - state=FETCH
  - counters, `halted` and `error` to 0
  - class register to ALU
  - wait counter to 0
- Reset asserted mid-instruction (any state, including HALT) aborts the instruction with no strobes on the reset edge.
- First cycle after reset release: `imem_req`=1.
- Cycles per instruction with zero-wait memory (ready in the request cycle):
  - BRANCH: 3
  - ALU, UPPER, JUMP, STORE: 4
  - LOAD: 5
  - Each memory wait cycle adds 1.
- Ready inputs are ignored outside FETCH and MEM; ready held high across states has no effect.
- `cycle_cnt` increments every non-HALT cycle after reset; wraps at 2^CNT_W with no flag.
- Timeout and ready arriving in the same cycle: ready wins.

## Structure
- Shared package `mc_pkg` contains:
  - `state_t` enum (3-bit)
  - `iclass_t` enum
  - opcode constants (OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM)
- Sub-module `opclass_decode`: purely combinational, OpCode → `iclass_t`; reusable by the control unit.
- Top-level integration: `PcWr` gates the `pc` register and `IrWr` loads a new IR. `RUWrEn` and `DMWrEn` are ANDed with the existing `RUWr` and `DMWr`.

## Test plan
- Reset, then ADDI (0010011) with both memories zero-wait → strobes in order: IrWr at cycle 0, RUWrEn+PcWr at cycle 3; `instret`=1, `cycle_cnt`=4.
- LW with `dmem_ready` delayed 3 cycles → MEM held 4 cycles with `dmem_req`=1; RUWrEn in cycle 7; total 8 cycles, one PcWr.
- BEQ followed by SW, zero-wait → PcWr in cycle 2 (branch); SW shows DMWrEn=1 only in its MEM cycle, PcWr at its cycle 3; `instret`=2.
- OpCode 0000000 → HALT after DECODE with `halted`=1, `error`=1. `cycle_cnt` freezes at 2; `imem_ready` pulses afterwards cause no strobes.
- TIMEOUT=4 with `imem_ready` held 0 → HALT with `error`=1 at the edge after the 4th FETCH wait cycle. A run where ready arrives in the 4th wait cycle instead gives a normal IrWr.
- ECALL (1110011) → HALT with `error`=0. Asserting `rst_n`=0 for one edge mid-MEM of a store, then releasing → no DMWrEn on the reset edge; all counters 0; state FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared state/class types and RV32I opcode constants for the multicycle
// sequencer and the control unit.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU     = 3'd0,
    IC_LOAD    = 3'd1,
    IC_STORE   = 3'd2,
    IC_BRANCH  = 3'd3,
    IC_JUMP    = 3'd4,
    IC_UPPER   = 3'd5,
    IC_SYSTEM  = 3'd6,
    IC_ILLEGAL = 3'd7
  } iclass_t;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/opclass_decode.sv
// Combinational RV32I opcode classifier; shared by the sequencer and the
// control unit so both agree on what counts as a legal instruction.
module opclass_decode
  import mc_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_t    o_iclass
);

  always_comb begin
    // NOTE: every path assigns o_iclass (default arm included), so no latch is inferred.
    case (i_opcode)
      OP_ALU_R, OP_ALU_I: o_iclass = IC_ALU;
      OP_LOAD:            o_iclass = IC_LOAD;
      OP_STORE:           o_iclass = IC_STORE;
      OP_BRANCH:          o_iclass = IC_BRANCH;
      OP_JAL, OP_JALR:    o_iclass = IC_JUMP;
      OP_LUI, OP_AUIPC:   o_iclass = IC_UPPER;
      OP_SYSTEM:          o_iclass = IC_SYSTEM;
      default:            o_iclass = IC_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and gates the datapath's state-changing strobes.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       OpCode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             IrWr,
  output logic             PcWr,
  output logic             RUWrEn,
  output logic             DMWrEn,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  iclass_t           r_iclass;
  logic [WAIT_W-1:0] r_wait;
  logic              r_error;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_instret;

  iclass_t w_iclass;
  logic    w_imem_req, w_dmem_req, w_ir_wr, w_pc_wr, w_ru_wr_en, w_dm_wr_en;
  logic    w_ready, w_waiting, w_timeout;

  opclass_decode u_decode (
    .i_opcode (OpCode),
    .o_iclass (w_iclass)
  );

  // Strobes come from state and the registered class; ready only matters in FETCH/MEM.
  always_comb begin
    w_imem_req = (r_state == ST_FETCH);
    w_dmem_req = (r_state == ST_MEM);
    w_ir_wr    = w_imem_req && imem_ready;
    w_dm_wr_en = w_dmem_req && (r_iclass == IC_STORE);
    w_ru_wr_en = (r_state == ST_WB);
    w_pc_wr    = w_ru_wr_en
              || ((r_state == ST_EXEC) && (r_iclass == IC_BRANCH))
              || (w_dm_wr_en && dmem_ready);
    w_ready    = (w_imem_req && imem_ready) || (w_dmem_req && dmem_ready);
    w_waiting  = (w_imem_req || w_dmem_req) && !w_ready;
    w_timeout  = w_waiting && (r_wait == WAIT_LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      r_state     <= ST_FETCH;
      r_iclass    <= IC_ALU;
      r_wait      <= '0;
      r_error     <= 1'b0;
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if (r_state != ST_HALT) r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (w_pc_wr)            r_instret   <= r_instret + CNT_W'(1);
      r_wait <= (w_waiting && !w_timeout) ? r_wait + WAIT_W'(1) : '0;

      case (r_state)
        ST_FETCH: begin
          if (imem_ready) begin
            r_state <= ST_DECODE;
          end else if (w_timeout) begin
            r_state <= ST_HALT;
            r_error <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_iclass <= w_iclass;
          if (w_iclass == IC_SYSTEM) begin
            r_state <= ST_HALT;
          end else if (w_iclass == IC_ILLEGAL) begin
            r_state <= ST_HALT;
            r_error <= 1'b1;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_iclass == IC_BRANCH)
            r_state <= ST_FETCH;
          else if (r_iclass == IC_LOAD || r_iclass == IC_STORE)
            r_state <= ST_MEM;
          else
            r_state <= ST_WB;
        end
        ST_MEM: begin
          if (dmem_ready) begin
            r_state <= (r_iclass == IC_LOAD) ? ST_WB : ST_FETCH;
          end else if (w_timeout) begin
            r_state <= ST_HALT;
            r_error <= 1'b1;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_HALT: r_state <= ST_HALT;
        default: begin
          r_state <= ST_HALT;
          r_error <= 1'b1;
        end
      endcase
    end
  end

  // Everything is held low while reset is asserted, so an aborted instruction leaves no trace.
  assign imem_req  = rst_n && w_imem_req;
  assign dmem_req  = rst_n && w_dmem_req;
  assign IrWr      = rst_n && w_ir_wr;
  assign PcWr      = rst_n && w_pc_wr;
  assign RUWrEn    = rst_n && w_ru_wr_en;
  assign DMWrEn    = rst_n && w_dm_wr_en;
  assign halted    = rst_n && (r_state == ST_HALT);
  assign error     = rst_n && r_error;
  assign state     = rst_n ? r_state : 3'd0;
  assign cycle_cnt = rst_n ? r_cycle_cnt : '0;
  assign instret   = rst_n ? r_instret : '0;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle expected strobe vectors are
// queued as stimulus is driven and compared on the following falling edge.
module tb_mc_sequencer;
  import mc_pkg::*;

  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 4;

  // Expected-strobe bit positions: {imem_req,dmem_req,IrWr,PcWr,RUWrEn,DMWrEn,halted,error}
  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_IREQ = 8'h80;
  localparam logic [7:0] S_DREQ = 8'h40;
  localparam logic [7:0] S_IRW  = 8'h20;
  localparam logic [7:0] S_PCW  = 8'h10;
  localparam logic [7:0] S_RUW  = 8'h08;
  localparam logic [7:0] S_DMW  = 8'h04;
  localparam logic [7:0] S_HLT  = 8'h02;
  localparam logic [7:0] S_ERR  = 8'h01;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [6:0]       OpCode = 7'h00;
  logic             imem_ready = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             imem_req, dmem_req, IrWr, PcWr, RUWrEn, DMWrEn, halted, error;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instret;

  int          checks = 0;
  int          errors = 0;
  int          cyc_idx = 0;
  logic [10:0] exp_q[$];
  logic [10:0] w_obs;

  always #5 clk = ~clk;

  mc_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .OpCode     (OpCode),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .IrWr       (IrWr),
    .PcWr       (PcWr),
    .RUWrEn     (RUWrEn),
    .DMWrEn     (DMWrEn),
    .halted     (halted),
    .error      (error),
    .state      (state),
    .cycle_cnt  (cycle_cnt),
    .instret    (instret)
  );

  assign w_obs = {imem_req, dmem_req, IrWr, PcWr, RUWrEn, DMWrEn, halted, error, state};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the strobe vector expected in that cycle.
  task automatic step(input logic rst, input logic [6:0] op, input logic ir, input logic dr,
                      input logic [7:0] s, input state_t st);
    @(negedge clk);
    rst_n      = rst;
    OpCode     = op;
    imem_ready = ir;
    dmem_ready = dr;
    exp_q.push_back({s, st});
  endtask

  // Counters after the edge that ends the most recently driven cycle.
  task automatic chk_cnt(input string tag, input logic [31:0] cc, input logic [31:0] ir);
    @(posedge clk);
    #1;
    check($sformatf("%s_cycle_cnt", tag), cycle_cnt, cc);
    check($sformatf("%s_instret", tag), instret, ir);
  endtask

  // Counters as seen at the start of the cycle just driven.
  task automatic chk_now(input string tag, input logic [31:0] cc, input logic [31:0] ir);
    #1;
    check($sformatf("%s_cycle_cnt", tag), cycle_cnt, cc);
    check($sformatf("%s_instret", tag), instret, ir);
  endtask

  always begin : monitor
    logic [10:0] e;
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check($sformatf("strobes_cyc%0d", cyc_idx), {21'b0, w_obs}, {21'b0, e});
      cyc_idx++;
    end
  end

  initial begin
    // Reset for two edges; all outputs held low.
    step(1'b0, 7'h00, 1'b1, 1'b1, S_NONE, ST_FETCH);
    step(1'b0, 7'h00, 1'b1, 1'b1, S_NONE, ST_FETCH);

    // ADDI, zero-wait; live OpCode goes illegal after DECODE to prove the class is registered.
    step(1'b1, OP_ALU_I, 1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    chk_now("reset", 0, 0);
    step(1'b1, OP_ALU_I, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,    1'b0, 1'b0, S_NONE, ST_EXEC);
    step(1'b1, 7'h00,    1'b1, 1'b1, S_RUW | S_PCW, ST_WB);
    chk_cnt("addi", 4, 1);

    // LW with dmem_ready delayed three cycles; ready in EXEC is ignored.
    step(1'b1, 7'h00,   1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,   1'b1, 1'b1, S_NONE, ST_EXEC);
    for (int i = 0; i < 3; i++) step(1'b1, 7'h00, 1'b0, 1'b0, S_DREQ, ST_MEM);
    step(1'b1, 7'h00,   1'b0, 1'b1, S_DREQ, ST_MEM);
    step(1'b1, 7'h00,   1'b0, 1'b0, S_RUW | S_PCW, ST_WB);
    chk_cnt("lw", 12, 2);

    // BEQ: three cycles, PcWr in EXEC.
    step(1'b1, 7'h00,     1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_BRANCH, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,     1'b0, 1'b0, S_PCW, ST_EXEC);
    chk_cnt("beq", 15, 3);

    // SW zero-wait: DMWrEn and PcWr only in the MEM cycle.
    step(1'b1, 7'h00,    1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,    1'b0, 1'b0, S_NONE, ST_EXEC);
    step(1'b1, 7'h00,    1'b0, 1'b1, S_DREQ | S_DMW | S_PCW, ST_MEM);
    chk_cnt("sw", 19, 4);

    // JAL after two fetch wait cycles.
    step(1'b1, 7'h00,  1'b0, 1'b0, S_IREQ, ST_FETCH);
    step(1'b1, 7'h00,  1'b0, 1'b0, S_IREQ, ST_FETCH);
    step(1'b1, 7'h00,  1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_JAL, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,  1'b0, 1'b0, S_NONE, ST_EXEC);
    step(1'b1, 7'h00,  1'b0, 1'b0, S_RUW | S_PCW, ST_WB);
    chk_cnt("jal", 25, 5);

    // LUI: ready arrives in the 4th wait cycle, which still wins over the timeout.
    for (int i = 0; i < 3; i++) step(1'b1, 7'h00, 1'b0, 1'b0, S_IREQ, ST_FETCH);
    step(1'b1, 7'h00,  1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_LUI, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,  1'b0, 1'b0, S_NONE, ST_EXEC);
    step(1'b1, 7'h00,  1'b0, 1'b0, S_RUW | S_PCW, ST_WB);
    chk_cnt("lui", 32, 6);

    // SW interrupted by reset in MEM: no DMWrEn on the reset edge, counters cleared.
    step(1'b1, 7'h00,    1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_STORE, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,    1'b0, 1'b0, S_NONE, ST_EXEC);
    step(1'b1, 7'h00,    1'b0, 1'b0, S_DREQ | S_DMW, ST_MEM);
    step(1'b0, 7'h00,    1'b0, 1'b1, S_NONE, ST_FETCH);
    step(1'b1, 7'h00,    1'b0, 1'b0, S_IREQ, ST_FETCH);
    chk_now("rst_mid_mem", 0, 0);

    // ECALL: clean halt, counters frozen, ready pulses ignored.
    step(1'b1, 7'h00,     1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_SYSTEM, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,     1'b1, 1'b1, S_HLT, ST_HALT);
    step(1'b1, 7'h00,     1'b1, 1'b1, S_HLT, ST_HALT);
    chk_cnt("ecall", 3, 0);

    // Reset out of HALT, then illegal opcode 0000000.
    step(1'b0, 7'h00, 1'b0, 1'b0, S_NONE, ST_FETCH);
    step(1'b1, 7'h00, 1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    chk_now("rst_halt", 0, 0);
    step(1'b1, 7'h00, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00, 1'b1, 1'b0, S_HLT | S_ERR, ST_HALT);
    step(1'b1, 7'h00, 1'b1, 1'b1, S_HLT | S_ERR, ST_HALT);
    step(1'b1, 7'h00, 1'b0, 1'b0, S_HLT | S_ERR, ST_HALT);
    chk_cnt("illegal", 2, 0);

    // Fetch timeout: four wait cycles, then HALT with error.
    step(1'b0, 7'h00, 1'b0, 1'b0, S_NONE, ST_FETCH);
    for (int i = 0; i < 4; i++) step(1'b1, 7'h00, 1'b0, 1'b0, S_IREQ, ST_FETCH);
    step(1'b1, 7'h00, 1'b1, 1'b0, S_HLT | S_ERR, ST_HALT);
    chk_cnt("fetch_timeout", 4, 0);

    // Data-side timeout during a load.
    step(1'b0, 7'h00,   1'b0, 1'b0, S_NONE, ST_FETCH);
    step(1'b1, 7'h00,   1'b1, 1'b0, S_IREQ | S_IRW, ST_FETCH);
    step(1'b1, OP_LOAD, 1'b0, 1'b0, S_NONE, ST_DECODE);
    step(1'b1, 7'h00,   1'b0, 1'b0, S_NONE, ST_EXEC);
    for (int i = 0; i < 4; i++) step(1'b1, 7'h00, 1'b0, 1'b0, S_DREQ, ST_MEM);
    step(1'b1, 7'h00,   1'b0, 1'b1, S_HLT | S_ERR, ST_HALT);
    chk_cnt("mem_timeout", 7, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
